// File: rtl/sqrt_bist.sv
// Self-test sequencer for a WIDTH-bit integer square-root unit: sweeps [lo, hi],
// checks each result arithmetically and keeps pass/fail statistics.
module sqrt_bist_chk #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] res,
  output logic             ok
);
  logic [2*WIDTH-1:0] sq;
  logic [2*WIDTH+1:0] r1, sq1;

  // (res+1)^2 is formed two bits wider so res = all-ones cannot overflow
  assign sq  = {{WIDTH{1'b0}}, res} * {{WIDTH{1'b0}}, res};
  assign r1  = {{(WIDTH+2){1'b0}}, res} + {{(2*WIDTH+1){1'b0}}, 1'b1};
  assign sq1 = r1 * r1;
  assign ok  = (sq <= {{WIDTH{1'b0}}, x}) && (sq1 > {{(WIDTH+2){1'b0}}, x});
endmodule

module sqrt_bist #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] res_in,
  output logic [WIDTH-1:0] x_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   tested,
  output logic [WIDTH:0]   fail_count,
  output logic [WIDTH-1:0] first_fail_x,
  output logic [WIDTH-1:0] first_fail_res
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q;
  logic             ok;

  sqrt_bist_chk #(.WIDTH(WIDTH)) u_chk (
    .x   (x_out),
    .res (res_in),
    .ok  (ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      hi_q           <= '0;
      x_out          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      tested         <= '0;
      fail_count     <= '0;
      first_fail_x   <= '0;
      first_fail_res <= '0;
    end else if (abort) begin
      // statistics are kept after an abort so the partial sweep can be inspected
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            hi_q           <= hi_in;
            x_out          <= lo_in;
            cnt            <= RELOAD;
            tested         <= '0;
            fail_count     <= '0;
            first_fail_x   <= '0;
            first_fail_res <= '0;
            if (lo_in > hi_in) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= SETTLE;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= CHECK;
          else           cnt   <= cnt - 1'b1;
        end
        CHECK: begin
          tested <= tested + 1'b1;
          if (!ok) begin
            fail_count <= fail_count + 1'b1;
            if (fail_count == '0) begin
              first_fail_x   <= x_out;
              first_fail_res <= res_in;
            end
          end
          // equality, not x_out > hi, so a sweep ending at all-ones never wraps
          if (x_out == hi_q) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= ok && (fail_count == '0);
          end else begin
            x_out <= x_out + 1'b1;
            cnt   <= RELOAD;
            state <= SETTLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_bist.sv
// Scoreboarded bench for sqrt_bist: a table-driven sqrt model with injectable
// faults feeds res_in; expected sweep results are pushed per start and checked on done.
module tb_sqrt_bist;
  localparam int W = 16;
  localparam int S = 1;

  logic clk = 1'b0;
  logic reset, start, abort;
  logic [W-1:0] lo_in, hi_in, res_in, x_out;
  logic busy, done, pass;
  logic [W:0] tested, fail_count;
  logic [W-1:0] first_fail_x, first_fail_res;

  sqrt_bist #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .lo_in(lo_in), .hi_in(hi_in), .res_in(res_in), .x_out(x_out),
    .busy(busy), .done(done), .pass(pass), .tested(tested),
    .fail_count(fail_count), .first_fail_x(first_fail_x),
    .first_fail_res(first_fail_res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // sqrt unit model
  logic [W-1:0] gold      [0:65535];
  logic         fault_en  [0:65535];
  logic [W-1:0] fault_val [0:65535];
  assign res_in = fault_en[x_out] ? fault_val[x_out] : gold[x_out];

  typedef struct {
    int tested; int fails; int ffx; int ffr; bit pass; int xo; int lat; int start_cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int returned(int x);
    return fault_en[x] ? int'(fault_val[x]) : int'(gold[x]);
  endfunction

  function automatic exp_t model(int lo, int hi);
    exp_t e;
    e = '{default: 0};
    if (lo > hi) begin
      e.pass = 1'b1; e.xo = lo; e.lat = 0;
      return e;
    end
    for (int x = lo; x <= hi; x++) begin
      e.tested++;
      if (returned(x) != int'(gold[x])) begin
        if (e.fails == 0) begin e.ffx = x; e.ffr = returned(x); end
        e.fails++;
      end
    end
    e.pass = (e.fails == 0);
    e.xo   = hi;
    e.lat  = (hi - lo + 1) * (S + 1);
    return e;
  endfunction

  task automatic clear_faults();
    for (int x = 0; x < 65536; x++) begin fault_en[x] = 1'b0; fault_val[x] = '0; end
  endtask

  task automatic add_fault(int x, int v);
    fault_en[x] = 1'b1; fault_val[x] = v[W-1:0];
  endtask

  task automatic pulse_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic raw_start(int lo, int hi);
    @(negedge clk);
    lo_in = lo[W-1:0]; hi_in = hi[W-1:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic go(int lo, int hi, bit pre_abort);
    exp_t e;
    if (pre_abort) pulse_abort();
    e = model(lo, hi);
    raw_start(lo, hi);
    e.start_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_sb(int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin @(negedge clk); n++; end
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout: done not seen within %0d cycles, %0d pending", budget, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_x(int v);
    int n = 0;
    while (x_out !== v[W-1:0] && n < 2000) begin @(negedge clk); n++; end
    if (x_out !== v[W-1:0]) begin
      checks++; errors++;
      $display("FAIL wait_x: x_out %0h never reached %0h", x_out, v);
    end
  endtask

  // monitor: on each rising done, pop the oldest expectation and compare
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (reset) done_q = 1'b0;
    else begin
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending sweep");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("tested",         32'(tested),         32'(e.tested));
          chk("fail_count",     32'(fail_count),     32'(e.fails));
          chk("first_fail_x",   32'(first_fail_x),   32'(e.ffx));
          chk("first_fail_res", 32'(first_fail_res), 32'(e.ffr));
          chk("pass",           32'(pass),           32'(e.pass));
          chk("x_out_at_done",  32'(x_out),          32'(e.xo));
          chk("done_latency",   32'(cyc - e.start_cyc), 32'(e.lat));
        end
      end
      done_q = done;
    end
  end

  initial begin
    int r;
    r = 0;
    for (int x = 0; x < 65536; x++) begin
      while ((r + 1) * (r + 1) <= x) r++;
      gold[x] = r[W-1:0];
    end
    clear_faults();
    reset = 1'b1; start = 1'b0; abort = 1'b0; lo_in = '0; hi_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_x_out", 32'(x_out), 0);
    chk("rst_flags", {busy, done, pass}, 0);
    chk("rst_tested", 32'(tested), 0);
    chk("rst_fail", 32'(fail_count), 0);
    reset = 1'b0;

    // top of range: must stop at FFFF and hold it
    go(16'hFF00, 16'hFFFF, 1'b0);
    wait_sb(1200);
    repeat (4) @(negedge clk);
    chk("no_wrap_x_out", 32'(x_out), 32'hFFFF);
    chk("no_wrap_done", 32'(done), 1);

    clear_faults(); add_fault(16'h10, 5);
    go(0, 255, 1'b1); wait_sb(600);

    clear_faults(); add_fault(16'h30, 2); add_fault(16'h90, 0);
    go(0, 255, 1'b0); wait_sb(600);
    clear_faults();

    go(16'hFFFF, 16'hFFFF, 1'b1); wait_sb(20);

    go(16'h0100, 16'h00FF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("empty_busy", 32'(busy), 0);
      @(negedge clk);
    end
    wait_sb(10);
    go(16'hFFFF, 16'h0000, 1'b1); wait_sb(10);

    // start while busy is ignored
    go(0, 255, 1'b1);
    wait_x(16'h40);
    lo_in = 16'h1234; hi_in = 16'h0010; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_sb(600);

    // randomized sweeps with injected faults, sometimes restarted straight from DONE
    for (int t = 0; t < 12; t++) begin
      int lo, hi, len, nf;
      bit pa;
      clear_faults();
      lo  = $urandom_range(0, 65535);
      len = $urandom_range(1, 700);
      hi  = (lo + len - 1 > 65535) ? 65535 : lo + len - 1;
      nf  = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        int fx;
        fx = $urandom_range(lo, hi);
        add_fault(fx, int'(gold[fx]) ^ $urandom_range(1, 65535));
      end
      pa = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) begin
        int tmp; tmp = lo; lo = hi + 1; hi = tmp;
        if (lo > 65535) begin lo = 65535; hi = 0; end
        pa = 1'b1;
      end
      go(lo, hi, pa);
      wait_sb((hi - lo + 1 > 0 ? hi - lo + 1 : 1) * (S + 1) + 20);
    end
    clear_faults();

    // abort mid-sweep keeps the partial count
    pulse_abort();
    raw_start(0, 255);
    wait_x(16'h40);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_flags", {busy, done, pass}, 0);
    chk("abort_tested", 32'(tested), 32'h40);
    repeat (3) @(negedge clk);
    chk("abort_idle_x", 32'(x_out), 32'h40);

    // asynchronous reset mid-sweep
    raw_start(0, 255);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_x_out", 32'(x_out), 0);
    chk("arst_flags", {busy, done, pass}, 0);
    chk("arst_tested", 32'(tested), 0);
    chk("arst_fail", 32'(fail_count), 0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_idle", {busy, done}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
